// File: rtl/axi4_stream_packet_master.sv
// AXI4-Stream packet master: serialises NOPS operands onto the outbound stream, then collects one result packet.
// Optional inbound packet-length checking is enabled by defining AXIS_TLAST_CHECK_EN.
module axi4_stream_packet_master #(
   parameter int SZ   = 32,
   parameter int DSZ  = 8,
   parameter int NOPS = 2,
   parameter int RSZ  = 2*SZ
) (
   input  logic                clk,
   input  logic                rst,
   output logic                out_clk,
   input  logic                start,
   input  logic [NOPS*SZ-1:0]  ops,
   output logic                busy,
   output logic [RSZ-1:0]      res,
   output logic                res_valid,
   output logic                err,
   output logic [DSZ-1:0]      tdata_to_slave,
   output logic                tvalid_to_slave,
   output logic                tlast_to_slave,
   input  logic                tready_to_slave,
   input  logic [DSZ-1:0]      tdata_to_master,
   input  logic                tvalid_to_master,
   input  logic                tlast_to_master,
   output logic                tready_to_master
);
   localparam int OUT_BEATS = NOPS*SZ/DSZ;
   localparam int IN_BEATS  = RSZ/DSZ;
   localparam int OCW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
   localparam int ICW = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;

   typedef enum logic [1:0] {IDLE, SEND, RECV, DRAIN} state_t;
   state_t state, state_nxt;

   logic [NOPS*SZ-1:0] shadow;
   logic [RSZ-1:0]     stage, stage_nxt;
   logic [OCW-1:0]     out_cnt;
   logic [ICW-1:0]     in_cnt;
   logic out_hs, in_hs, out_last, in_last, len_short, len_long;

   assign out_clk  = clk;
   assign out_hs   = (state == SEND) && tready_to_slave;
   assign in_hs    = (state == RECV) && tvalid_to_master;
   assign out_last = (out_cnt == OCW'(OUT_BEATS-1));
   assign in_last  = (in_cnt == ICW'(IN_BEATS-1));

`ifdef AXIS_TLAST_CHECK_EN
   logic err_q;
   assign len_short = in_hs && tlast_to_master && !in_last;
   assign len_long  = in_hs && in_last && !tlast_to_master;
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (rst)                        err_q <= 1'b0;
      else if (len_short || len_long) err_q <= 1'b1;
      else if (state == IDLE && start) err_q <= 1'b0;
   end
`else
   assign len_short = 1'b0;
   assign len_long  = 1'b0;
   assign err       = 1'b0;
`endif

   always_comb begin
      stage_nxt = stage;
      stage_nxt[in_cnt*DSZ +: DSZ] = tdata_to_master;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = SEND;
         SEND:  if (out_hs && out_last) state_nxt = RECV;
         RECV: begin
            if (len_short)              state_nxt = IDLE;
            else if (len_long)          state_nxt = DRAIN;
            else if (in_hs && in_last)  state_nxt = IDLE;
         end
         DRAIN: if (tvalid_to_master && tlast_to_master) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode registered state/counters only, so nothing is combinational from inputs.
   always_comb begin
      tvalid_to_slave  = (state == SEND);
      tlast_to_slave   = (state == SEND) && out_last;
      tdata_to_slave   = (state == SEND) ? shadow[out_cnt*DSZ +: DSZ] : '0;
      tready_to_master = (state == RECV) || (state == DRAIN);
      busy             = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow    <= '0;
         stage     <= '0;
         res       <= '0;
         res_valid <= 1'b0;
         out_cnt   <= '0;
         in_cnt    <= '0;
      end else begin
         res_valid <= 1'b0;
         if (state == IDLE && start) begin
            shadow  <= ops;
            out_cnt <= '0;
            in_cnt  <= '0;
         end
         if (out_hs) out_cnt <= out_cnt + 1'b1;
         if (in_hs) begin
            stage  <= stage_nxt;
            in_cnt <= in_cnt + 1'b1;
            if (in_last && !len_long) begin
               res       <= stage_nxt;
               res_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/axi4_stream_packet_master.md
# axi4_stream_packet_master

Parametrised AXI4-Stream transaction master. It serialises NOPS operands of SZ bits into a DSZ-wide outbound packet, then collects one RSZ-bit result packet from the peer slave. It replaces the free-running two-operand master wrapper: it adds start/busy/done control, correct AXI valid/data hold under backpressure, and optional inbound packet-length checking. It sits between the compute test harness and any AXI4-Stream slave datapath.

## Interface
- SZ, 32, operand width in bits; must be a multiple of DSZ
- DSZ, 8, stream beat width (tdata width)
- NOPS, 2, number of operands per request; OUT_BEATS = NOPS*SZ/DSZ
- RSZ, 2*SZ, result width; must be a multiple of DSZ; IN_BEATS = RSZ/DSZ
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- out_clk  out  1  copy of clk, for the slave
- start  in  1  request pulse; sampled only in IDLE
- ops  in  NOPS*SZ  operands, operand 0 in the LSBs
- busy  out  1  high from accepted start until result or error completion
- res  out  RSZ  last good result, beat 0 in the LSBs
- res_valid  out  1  one-cycle pulse when res is updated
- err  out  1  sticky packet-length error, cleared on accepted start
- tdata_to_slave / tvalid_to_slave / tlast_to_slave  out  DSZ/1/1  outbound stream
- tready_to_slave  in  1
- tdata_to_master / tvalid_to_master / tlast_to_master  in  DSZ/1/1  inbound stream
- tready_to_master  out  1

## Operation
- Reset values: all outputs 0, including tvalid_to_slave, tready_to_master, busy, res, res_valid and err. State goes to IDLE and all counters to 0.
- FSM states: IDLE, SEND, RECV, DRAIN.
- IDLE: start=1 does the following:
  - ops is latched into a shadow register.
  - err is cleared and busy is set.
  - State goes to SEND with tvalid_to_slave=1 and tdata = shadow[DSZ-1:0].
- SEND: beat i = shadow[i*DSZ +: DSZ], little-endian.
  - tdata, tvalid and tlast are held stable while tvalid & ~tready.
  - A handshake advances the beat counter.
  - tlast_to_slave=1 only on beat OUT_BEATS-1.
  - The handshake on the final beat drops tvalid and moves to RECV.
- RECV: tready_to_master=1. Each handshake writes beat j into a staging register at [j*DSZ +: DSZ].
  - On the handshake of beat IN_BEATS-1 (length valid): res is loaded from staging, res_valid is pulsed, busy drops and state goes to IDLE.
- DRAIN (check builds only): tready_to_master=1. Beats are accepted and discarded until a beat with tlast, then the block goes to IDLE with busy=0 and no res_valid.
- start in any state other than IDLE is ignored; it is not queued.
- tready_to_master=0 in IDLE and SEND. Inbound beats arriving early stall at the slave.
- rst mid-operation: outputs return to reset values the next cycle. A partial packet is abandoned, and res is cleared.

## Timing
- start sampled at edge k. Beat 0 is valid after edge k, so there is no bubble.
- With tready_to_slave held 1, beat i handshakes at edge k+1+i and RECV begins after edge k+OUT_BEATS.
- Last inbound beat handshaked at edge m gives res/res_valid=1 and busy=0 after edge m. A new start can be accepted at edge m+1.
- Minimum transaction time is OUT_BEATS + IN_BEATS cycles.
- No combinational path from any input to any output. All stream outputs are registered.

## Configuration
- AXIS_TLAST_CHECK_EN defined:
  - An inbound tlast=1 on beat j<IN_BEATS-1 sets err, leaves res unchanged, suppresses res_valid, and goes to IDLE.
  - tlast=0 on beat IN_BEATS-1 sets err and goes to DRAIN.
- AXIS_TLAST_CHECK_EN undefined:
  - tlast_to_master is ignored and the packet ends purely on beat count.
  - err is tied to 0 and DRAIN is unreachable.

## Test plan
- Defaults, ops={0x08070605,0x04030201}, tready_to_slave=1 → tdata 01..08 on 8 consecutive cycles with tlast only on 08. Reply 0x11..0x88 with tlast on the 8th beat → res=0x8877665544332211 with one res_valid pulse and busy=0 after that edge.
- tready_to_slave toggling 1,0,1,0 → each beat held stable while stalled; sequence 01..08 unchanged; tlast still on 08 only.
- start pulsed again during SEND, and rst asserted at beat 4 → second start ignored; after rst, tvalid_to_slave=0, busy=0, res=0 next cycle.
- AXIS_TLAST_CHECK_EN, tlast on inbound beat 5 (index 4) → err=1, no res_valid, res keeps the prior value. Next start clears err.
- AXIS_TLAST_CHECK_EN, no tlast on beat 8, tlast on beat 10 → beats 9–10 accepted and discarded, err=1, IDLE after beat 10, no res_valid.
- Check disabled, tlast on inbound beat 3 → ignored; res assembled from all 8 beats; err stays 0.
